// File: rtl/key_event.sv
// key_event: turns debounced key levels into press/short/long/release pulses.
// Optional auto-repeat pulses are built when KEY_REPEAT_EN is defined.
module key_event #(
    parameter int TICK_MAX  = 49_999,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] key_deb,
    output logic [3:0] key_press,
    output logic [3:0] key_short,
    output logic [3:0] key_long,
    output logic [3:0] key_rpt,
    output logic [3:0] key_release,
    output logic [1:0] key_code,
    output logic       key_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_LONG
    } state_e;

    localparam logic [16:0] TICK_W = 17'(TICK_MAX);
    localparam logic [11:0] LONG_W = 12'(LONG_MS);

    logic [16:0] cnt_q, cnt_d;
    logic        tick;
    logic [3:0]  key_d_q;
    logic [3:0]  rise, fall;

    state_e      state_q [4];
    state_e      state_d [4];
    logic [11:0] ms_q    [4];
    logic [11:0] ms_d    [4];

    logic [3:0]  press_q, press_d;
    logic [3:0]  short_q, short_d;
    logic [3:0]  long_q, long_d;
    logic [3:0]  rel_q, rel_d;
    logic [1:0]  code_q, code_d;
    logic        valid_q, valid_d;

`ifdef KEY_REPEAT_EN
    localparam logic [11:0] REP_W = 12'(REPEAT_MS);
    logic [3:0]  rpt_q, rpt_d;
`endif

    assign rise = key_deb & ~key_d_q;
    assign fall = ~key_deb & key_d_q;

    // Free-running millisecond prescaler; tick marks the terminal count.
    always_comb begin
        tick  = (cnt_q == TICK_W);
        cnt_d = tick ? '0 : cnt_q + 17'd1;
    end

    // Per-key press/hold FSMs plus the last-pressed key code.
    always_comb begin
        press_d = '0;
        short_d = '0;
        long_d  = '0;
        rel_d   = '0;
`ifdef KEY_REPEAT_EN
        rpt_d   = '0;
`endif
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            ms_d[i]    = ms_q[i];
            unique case (state_q[i])
                S_IDLE: begin
                    if (rise[i]) begin
                        state_d[i] = S_HELD;
                        ms_d[i]    = '0;
                        press_d[i] = 1'b1;
                    end
                end
                S_HELD: begin
                    if (fall[i]) begin
                        state_d[i] = S_IDLE;
                        short_d[i] = 1'b1;
                        rel_d[i]   = 1'b1;
                    end else if (tick) begin
                        if (ms_q[i] + 12'd1 == LONG_W) begin
                            state_d[i] = S_LONG;
                            ms_d[i]    = '0;
                            long_d[i]  = 1'b1;
                        end else begin
                            ms_d[i] = ms_q[i] + 12'd1;
                        end
                    end
                end
                S_LONG: begin
                    if (fall[i]) begin
                        state_d[i] = S_IDLE;
                        rel_d[i]   = 1'b1;
                    end
`ifdef KEY_REPEAT_EN
                    else if (tick) begin
                        if (ms_q[i] + 12'd1 == REP_W) begin
                            ms_d[i]  = '0;
                            rpt_d[i] = 1'b1;
                        end else begin
                            ms_d[i] = ms_q[i] + 12'd1;
                        end
                    end
`endif
                end
                default: state_d[i] = S_IDLE;
            endcase
        end
        valid_d = |rise;
        code_d  = code_q;
        for (int i = 3; i >= 0; i--) begin
            if (rise[i]) code_d = 2'(i);
        end
    end

    // State, counters and registered output pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            key_d_q <= '0;
            press_q <= '0;
            short_q <= '0;
            long_q  <= '0;
            rel_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= S_IDLE;
                ms_q[i]    <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            key_d_q <= key_deb;
            press_q <= press_d;
            short_q <= short_d;
            long_q  <= long_d;
            rel_q   <= rel_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                ms_q[i]    <= ms_d[i];
            end
        end
    end

`ifdef KEY_REPEAT_EN
    // Registered auto-repeat pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rpt_q <= '0;
        else       rpt_q <= rpt_d;
    end
    assign key_rpt = rpt_q;
`else
    assign key_rpt = '0;
`endif

    assign key_press   = press_q;
    assign key_short   = short_q;
    assign key_long    = long_q;
    assign key_release = rel_q;
    assign key_code    = code_q;
    assign key_valid   = valid_q;

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: scoreboard bench for key_event with a fast prescaler.
// Expected pulses are queued at stimulus time and popped as the DUT fires.
module tb_key_event;

    localparam int TICK_MAX  = 9;
    localparam int LONG_MS   = 5;
    localparam int REPEAT_MS = 3;
    localparam int TP        = TICK_MAX + 1;

    logic       clk;
    logic       rstn;
    logic [3:0] key_deb;
    logic [3:0] key_press, key_short, key_long, key_rpt, key_release;
    logic [1:0] key_code;
    logic       key_valid;

    key_event #(
        .TICK_MAX (TICK_MAX),
        .LONG_MS  (LONG_MS),
        .REPEAT_MS(REPEAT_MS)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .key_deb    (key_deb),
        .key_press  (key_press),
        .key_short  (key_short),
        .key_long   (key_long),
        .key_rpt    (key_rpt),
        .key_release(key_release),
        .key_code   (key_code),
        .key_valid  (key_valid)
    );

    typedef struct {
        int          cyc;
        logic [22:0] v;
    } ev_t;

    ev_t sb[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    int  ecnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges seen since reset release; the DUT prescaler runs in lockstep.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] pack(
        input logic [3:0] p, input logic [3:0] s, input logic [3:0] l,
        input logic [3:0] r, input logic [3:0] rl, input logic vd,
        input logic [1:0] c);
        return {p, s, l, r, rl, vd, c};
    endfunction

    function automatic logic [22:0] obs_all();
        return pack(key_press, key_short, key_long, key_rpt,
                    key_release, key_valid, key_code);
    endfunction

    task automatic push(input int cyc, input logic [22:0] v);
        ev_t e;
        e.cyc = cyc;
        e.v   = v;
        sb.push_back(e);
    endtask

    // Rise driven while ecnt==k, release driven while ecnt==k+n.
    task automatic push_hold(input logic [3:0] v, input int k, input int n,
                             input logic [1:0] c);
        int rel, t1, tl;
        bit lng;
        rel = k + n + 1;
        push(k + 1, pack(v, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, c));
        t1  = ((k + 1) / TP + 1) * TP;
        tl  = t1 + TP * (LONG_MS - 1);
        lng = (tl < rel);
        if (lng) push(tl, pack(4'h0, 4'h0, v, 4'h0, 4'h0, 1'b0, c));
`ifdef KEY_REPEAT_EN
        if (lng) begin
            for (int m = tl + TP * REPEAT_MS; m < rel; m += TP * REPEAT_MS)
                push(m, pack(4'h0, 4'h0, 4'h0, v, 4'h0, 1'b0, c));
        end
`endif
        push(rel, pack(4'h0, lng ? 4'h0 : v, 4'h0, 4'h0, v, 1'b0, c));
    endtask

    task automatic hold(input logic [3:0] v, input int n,
                        input logic [1:0] c);
        push_hold(v, ecnt, n, c);
        key_deb = v;
        repeat (n) @(negedge clk);
        key_deb = 4'h0;
        repeat (12) @(negedge clk);
    endtask

    // Any pulse or key_valid must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rstn && ((|{key_press, key_short, key_long, key_rpt,
                        key_release}) || key_valid)) begin
            if (sb.size() == 0) begin
                check("unexpected", 32'(obs_all()), 32'h0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("ev_cycle", ecnt, e.cyc);
                check("ev_value", 32'(obs_all()), 32'(e.v));
            end
        end
    end

    initial begin
        rstn    = 1'b0;
        key_deb = 4'h0;
        repeat (3) @(negedge clk);
        check("reset_out", 32'(obs_all()), 32'h0);
        rstn = 1'b1;
        repeat (100) begin
            @(negedge clk);
            check("idle_out", 32'(obs_all()), 32'h0);
        end

        hold(4'b0010, 20, 2'd1);
        hold(4'b0100, 120, 2'd2);
        hold(4'b1010, 20, 2'd1);

        push(ecnt + 1, pack(4'b0001, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 2'd0));
        key_deb = 4'b0001;
        repeat (15) @(negedge clk);
        rstn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("in_reset", 32'(obs_all()), 32'h0);
        end
        rstn = 1'b1;
        push_hold(4'b0001, 0, 100, 2'd0);
        repeat (100) @(negedge clk);
        key_deb = 4'h0;
        repeat (12) @(negedge clk);

        hold(4'b1000, 300, 2'd3);

        repeat (20) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
